// File: rtl/parking_lane_arbiter.sv
// Purpose : shares one slot-occupancy bitmap between the entry and exit lanes; grants one lane at a time.
// Latency : request seen in IDLE at edge T -> ack in cycle T+1 -> gate open T+2..T+1+GATE_CYCLES -> IDLE.
// Backpress: requests are level-held; the losing lane simply waits, and a full lot blocks entry only.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   entry_req           validated car waiting at the entry barrier (level)
//   exit_req, exit_slot car leaving, and the slot it claims to vacate (level)
//   entry_ack/slot      one-cycle grant pulse plus the allocated slot (0 when no ack)
//   exit_ack / exit_err one-cycle pulse: slot freed / slot invalid or not occupied
//   entry_gate/exit_gate barrier open windows of GATE_CYCLES cycles
//   no_space            entry waiting while the lot is full
//   occupancy           number of occupied slots
module parking_lane_arbiter #(
    parameter int NUM_SLOTS   = 50,
    parameter int SLOT_W      = 6,
    parameter int GATE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot,
    output logic              entry_ack,
    output logic [SLOT_W-1:0] entry_slot,
    output logic              exit_ack,
    output logic              exit_err,
    output logic              entry_gate,
    output logic              exit_gate,
    output logic              no_space,
    output logic [SLOT_W-1:0] occupancy
);

    // The gate counter runs 0..GATE_CYCLES-1, so it only needs to hold GATE_CYCLES-1.
    localparam int                GCW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GCW-1:0]    GATE_LAST = GCW'(GATE_CYCLES - 1);
    localparam logic [SLOT_W-1:0] FULL_CNT  = SLOT_W'(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = NUM_SLOTS'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT_IN = 3'd1,
        S_GATE_IN  = 3'd2,
        S_CHK_OUT  = 3'd3,
        S_GATE_OUT = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [NUM_SLOTS-1:0]  bitmap_q;
    logic [SLOT_W-1:0]     occ_q;
    logic                  last_exit_q;   // 1: most recent grant went to the exit lane
    logic [SLOT_W-1:0]     slot_q;        // exit slot captured at grant time
    logic [GCW-1:0]        gate_cnt_q;

    logic                  lot_full;
    logic                  entry_elig;
    logic                  exit_elig;
    logic                  grant_entry;
    logic                  grant_exit;
    logic                  gate_done;
    logic [SLOT_W-1:0]     free_idx;
    logic [NUM_SLOTS-1:0]  free_oh;
    logic                  slot_hit;
    logic [NUM_SLOTS-1:0]  slot_oh;

    // ------------------------------------------------------------------
    // Arbitration: on a tie the lane that did not win last time goes.
    // last_exit_q resets to 0 (entry), so the first tie favours exit.
    // ------------------------------------------------------------------
    always_comb begin
        lot_full    = (occ_q == FULL_CNT);
        entry_elig  = entry_req & ~lot_full;
        exit_elig   = exit_req;
        grant_entry = entry_elig & (~exit_elig | last_exit_q);
        grant_exit  = exit_elig & (~entry_elig | ~last_exit_q);
        gate_done   = (gate_cnt_q == GATE_LAST);
    end

    // Lowest-index free slot; scanning downward leaves the lowest clear bit last.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!bitmap_q[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
        free_oh = ONE_HOT0 << free_idx;
    end

    // Exit validity: an out-of-range index never matches any bitmap position,
    // so it falls through as a miss without a separate range compare.
    always_comb begin
        slot_hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                slot_hit = bitmap_q[i];
            end
        end
        slot_oh = ONE_HOT0 << slot_q;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_entry) begin
                    state_d = S_GRANT_IN;
                end else if (grant_exit) begin
                    state_d = S_CHK_OUT;
                end
            end
            S_GRANT_IN: state_d = S_GATE_IN;
            S_GATE_IN: begin
                if (gate_done) begin
                    state_d = S_IDLE;
                end
            end
            S_CHK_OUT:  state_d = slot_hit ? S_GATE_OUT : S_IDLE;
            S_GATE_OUT: begin
                if (gate_done) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all decoded from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        entry_ack  = (state_q == S_GRANT_IN);
        entry_slot = entry_ack ? free_idx : '0;
        exit_ack   = (state_q == S_CHK_OUT) & slot_hit;
        exit_err   = (state_q == S_CHK_OUT) & ~slot_hit;
        entry_gate = (state_q == S_GATE_IN);
        exit_gate  = (state_q == S_GATE_OUT);
        no_space   = entry_req & lot_full;
        occupancy  = occ_q;
    end

    // ------------------------------------------------------------------
    // Datapath: bitmap, count, round-robin pointer, exit slot, gate timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_q    <= '0;
            occ_q       <= '0;
            last_exit_q <= 1'b0;
            slot_q      <= '0;
            gate_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gate_cnt_q <= '0;
                    if (grant_entry) begin
                        last_exit_q <= 1'b0;
                    end else if (grant_exit) begin
                        last_exit_q <= 1'b1;
                        slot_q      <= exit_slot;
                    end
                end
                S_GRANT_IN: begin
                    // Never entered while full, so a free bit always exists.
                    bitmap_q   <= bitmap_q | free_oh;
                    occ_q      <= occ_q + SLOT_W'(1);
                    gate_cnt_q <= '0;
                end
                S_CHK_OUT: begin
                    // A set bit guarantees occ_q >= 1, so this cannot underflow.
                    if (slot_hit) begin
                        bitmap_q <= bitmap_q & ~slot_oh;
                        occ_q    <= occ_q - SLOT_W'(1);
                    end
                    gate_cnt_q <= '0;
                end
                S_GATE_IN, S_GATE_OUT: begin
                    gate_cnt_q <= gate_done ? '0 : gate_cnt_q + GCW'(1);
                end
                default: gate_cnt_q <= '0;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(entry_gate && exit_gate));
            assert (!(entry_ack && exit_ack));
            assert (occ_q <= FULL_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_parking_lane_arbiter.sv
module tb_parking_lane_arbiter;

    localparam int N  = 50;
    localparam int SW = 6;
    localparam int G  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          entry_req = 1'b0;
    logic          exit_req = 1'b0;
    logic [SW-1:0] exit_slot = '0;
    logic          entry_ack;
    logic [SW-1:0] entry_slot;
    logic          exit_ack;
    logic          exit_err;
    logic          entry_gate;
    logic          exit_gate;
    logic          no_space;
    logic [SW-1:0] occupancy;

    parking_lane_arbiter #(.NUM_SLOTS(N), .SLOT_W(SW), .GATE_CYCLES(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .exit_slot  (exit_slot),
        .entry_ack  (entry_ack),
        .entry_slot (entry_slot),
        .exit_ack   (exit_ack),
        .exit_err   (exit_err),
        .entry_gate (entry_gate),
        .exit_gate  (exit_gate),
        .no_space   (no_space),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Response kinds: 0 entry grant, 1 exit accepted, 2 exit rejected
    typedef struct {
        int kind;
        int slot;
    } exp_t;
    exp_t sb[$];

    // Reference model: the lot as an array of occupied flags plus a count
    bit occ_map[N];
    int m_occ  = 0;
    int m_last = 0;   // 0 entry, 1 exit

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) occ_map[i] = 1'b0;
        m_occ  = 0;
        m_last = 0;
        sb.delete();
    endtask

    // Predict every response a request pair produces, in grant order, and
    // queue them. A lane left over (entry while full) is reported back.
    task automatic plan(input bit e, input bit x, input int s,
                        output int nexp, output bit e_left);
        bit ep = e;
        bit xp = x;
        nexp = 0;
        for (int k = 0; k < 2; k++) begin
            bit ee = ep && (m_occ < N);
            bit xe = xp;
            if (!ee && !xe) break;
            if (ee && (!xe || m_last == 1)) begin
                int f = 0;
                for (int i = N - 1; i >= 0; i--) if (!occ_map[i]) f = i;
                occ_map[f] = 1'b1;
                m_occ++;
                m_last = 0;
                sb.push_back('{0, f});
                ep = 1'b0;
            end else begin
                if (s < N && occ_map[s]) begin
                    occ_map[s] = 1'b0;
                    m_occ--;
                    sb.push_back('{1, s});
                end else begin
                    sb.push_back('{2, s});
                end
                m_last = 1;
                xp = 1'b0;
            end
            nexp++;
        end
        e_left = ep;
    endtask

    // Monitor: pops the scoreboard on every response and tracks gate windows
    int ent_left = 0;
    int ext_left = 0;
    always @(negedge clk) begin
        if (reset) begin
            ent_left = 0;
            ext_left = 0;
        end else begin
            int kind;
            exp_t e;
            chk("entry_gate", int'(entry_gate), int'(ent_left > 0));
            chk("exit_gate", int'(exit_gate), int'(ext_left > 0));
            if (ent_left > 0) ent_left--;
            if (ext_left > 0) ext_left--;
            chk("one_resp", int'(entry_ack) + int'(exit_ack) + int'(exit_err) <= 1 ? 1 : 0, 1);
            if (!entry_ack) chk("entry_slot_idle", int'(entry_slot), 0);
            if (entry_ack || exit_ack || exit_err) begin
                kind = entry_ack ? 0 : (exit_ack ? 1 : 2);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual kind=%0d required none", kind);
                end else begin
                    e = sb.pop_front();
                    chk("resp_kind", kind, e.kind);
                    if (kind == 0 && e.kind == 0) chk("entry_slot", int'(entry_slot), e.slot);
                end
            end
            if (entry_ack) ent_left = G;
            if (exit_ack) ext_left = G;
        end
    end

    task automatic check_reset_state();
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_entry_ack", int'(entry_ack), 0);
        chk("rst_exit_ack", int'(exit_ack), 0);
        chk("rst_exit_err", int'(exit_err), 0);
        chk("rst_entry_gate", int'(entry_gate), 0);
        chk("rst_exit_gate", int'(exit_gate), 0);
        chk("rst_entry_slot", int'(entry_slot), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        entry_req = 1'b0;
        exit_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        model_clear();
    endtask

    // One transaction: raise the requested lanes together, drop each on its
    // response, then confirm the count once the FSM has settled in IDLE.
    task automatic txn(input bit e, input bit x, input int s);
        int nexp;
        bit eleft;
        int seen = 0;
        int budget = 0;
        plan(e, x, s, nexp, eleft);
        @(negedge clk);
        entry_req = e;
        exit_req = x;
        exit_slot = SW'(s);
        while (seen < nexp && budget < 200) begin
            @(negedge clk);
            budget++;
            if (entry_ack) begin
                seen++;
                entry_req = 1'b0;
            end
            if (exit_ack || exit_err) begin
                seen++;
                exit_req = 1'b0;
            end
        end
        chk("resp_count", seen, nexp);
        if (seen < nexp) sb.delete();
        if (eleft) begin
            repeat (G + 6) @(negedge clk);
            chk("no_space_full", int'(no_space), 1);
        end
        entry_req = 1'b0;
        exit_req = 1'b0;
        repeat (G + 3) @(negedge clk);
        chk("occupancy", int'(occupancy), m_occ);
        chk("no_space_idle", int'(no_space), 0);
    endtask

    // Entry grant, then reset lands in the second gate-open cycle.
    task automatic reset_in_gate();
        int nexp;
        bit eleft;
        int budget = 0;
        plan(1'b1, 1'b0, 0, nexp, eleft);
        @(negedge clk);
        entry_req = 1'b1;
        while (!entry_ack && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("mid_ack_seen", int'(entry_ack), 1);
        entry_req = 1'b0;
        @(negedge clk);
        chk("mid_gate1_occ", int'(occupancy), m_occ);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_gate", int'(entry_gate), 0);
        chk("mid_rst_occ", int'(occupancy), 0);
        reset = 1'b0;
        model_clear();
    endtask

    function automatic int pick_slot();
        int start;
        if ($urandom_range(0, 3) == 0 || m_occ == 0) return $urandom_range(0, 63);
        start = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
            if (occ_map[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Two entries: slots 0 then 1
        txn(1, 0, 0);
        txn(1, 0, 0);
        // Third entry, free slot 1, refill lowest free
        txn(1, 0, 0);
        txn(0, 1, 1);
        txn(1, 0, 0);

        // Tie handling after reset
        do_reset();
        txn(1, 0, 0);
        txn(1, 1, 0);
        txn(1, 1, 0);
        txn(0, 1, 0);
        txn(1, 1, 0);

        // Full lot
        do_reset();
        for (int i = 0; i < N; i++) txn(1, 0, 0);
        txn(1, 0, 0);
        txn(1, 1, 49);

        // Invalid exits
        txn(0, 1, 55);
        txn(0, 1, 7);
        txn(0, 1, 7);

        // Reset while the entry gate is open
        do_reset();
        txn(1, 0, 0);
        reset_in_gate();
        txn(1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 45)      txn(1, 0, 0);
            else if (r < 70) txn(0, 1, pick_slot());
            else             txn(1, 1, pick_slot());
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
